tx_iod_train_gen: RTL and testbench

TX_IOD_TRAIN_GEN -- requirements
Module: tx_iod_train_gen

---
 rtl/tx_iod_train_gen.sv | 158 +++++++++++++++
 tb/tb_tx_iod_train_gen.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_iod_train_gen.sv
// ---------------------------------------------------------------------------
// tx_iod_train_gen
//
// Link-training word generator for a TX IO-delay/serializer lane. After a
// training request it sends a fixed training word until the far-end aligner
// reports lock. It then passes payload words through, or the idle word when
// no payload is valid. If the aligner never locks, it parks in an error state
// that keeps sending the training word until training is requested again.
//
// Ports
//   SCLK          in   single clock, rising edge
//   RESET         in   synchronous, active-high reset
//   TRAIN_REQ     in   level request to (re)start training
//   RX_ALIGN_DONE in   far-end aligner lock, already synchronous to SCLK
//   TX_DATA_IN    in   [7:0] payload word, logical bit order
//   TX_VALID_IN   in   TX_DATA_IN valid
//   TX_READY      out  payload accepted this cycle (high only in DATA)
//   TX_DATA_OUT   out  [7:0] registered word to the serializer (wire order)
//   TRAINING      out  registered: state is TRAIN or WAIT_ALIGN
//   TRAIN_DONE    out  registered: state is DATA
//   TRAIN_ERR     out  registered: state is ERR
// ---------------------------------------------------------------------------
module tx_iod_train_gen #(
  parameter logic [7:0]  TRAIN_PATTERN   = 8'h0F,
  parameter logic [7:0]  IDLE_WORD       = 8'h00,
  parameter bit          REV_BITS        = 1'b1,
  parameter int unsigned MIN_TRAIN_WORDS = 256,
  parameter int unsigned ALIGN_TIMEOUT   = 4096
) (
  input  logic       SCLK,
  input  logic       RESET,
  input  logic       TRAIN_REQ,
  input  logic       RX_ALIGN_DONE,
  input  logic [7:0] TX_DATA_IN,
  input  logic       TX_VALID_IN,
  output logic       TX_READY,
  output logic [7:0] TX_DATA_OUT,
  output logic       TRAINING,
  output logic       TRAIN_DONE,
  output logic       TRAIN_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAIN,
    S_WAIT_ALIGN,
    S_DATA,
    S_ERR
  } state_e;

  localparam logic [15:0] TRAIN_LAST = 16'(MIN_TRAIN_WORDS - 1);
  localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_TIMEOUT - 1);

  // Map a logical word onto serializer lanes: with REV_BITS set, lane i
  // carries logical bit 7-i.
  function automatic logic [7:0] wire_order(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = REV_BITS ? w[7-i] : w[i];
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        training_q, training_d;
  logic        train_done_q, train_done_d;
  logic        train_err_q, train_err_d;
  logic [7:0]  word_sel;

  // -------------------------------------------------------------------------
  // State register (plus counter, output word and status flags)
  // -------------------------------------------------------------------------
  // NOTE: every flop here is assigned with <= so all registers update from
  // the same pre-edge values; a blocking = would let later lines see new ones.
  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      data_out_q   <= wire_order(IDLE_WORD);
      training_q   <= 1'b0;
      train_done_q <= 1'b0;
      train_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      training_q   <= training_d;
      train_done_q <= train_done_d;
      train_err_q  <= train_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and counter logic
  // -------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise always_comb would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (TRAIN_REQ) state_d = S_TRAIN;
      end
      // Alignment is deliberately ignored until the minimum word count is out.
      S_TRAIN: begin
        if (cnt_q == TRAIN_LAST) state_d = S_WAIT_ALIGN;
      end
      // Lock is tested before the timeout so a lock on the last cycle wins.
      S_WAIT_ALIGN: begin
        if (TRAIN_REQ)               state_d = S_TRAIN;
        else if (RX_ALIGN_DONE)      state_d = S_DATA;
        else if (cnt_q == ALIGN_LAST) state_d = S_ERR;
      end
      S_DATA: begin
        if (TRAIN_REQ || !RX_ALIGN_DONE) state_d = S_TRAIN;
      end
      S_ERR: begin
        if (TRAIN_REQ) state_d = S_TRAIN;
      end
      default: state_d = S_IDLE;
    endcase

    // Counter restarts at 0 on every state entry and saturates at all-ones.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_TRAIN || state_q == S_WAIT_ALIGN) && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    unique case (state_q)
      S_IDLE:  word_sel = IDLE_WORD;
      S_DATA:  word_sel = TX_VALID_IN ? TX_DATA_IN : IDLE_WORD;
      default: word_sel = TRAIN_PATTERN;
    endcase
    data_out_d = wire_order(word_sel);

    // Flags are decoded from the next state, so the registered copies track
    // the current state cycle for cycle and line up with TX_READY.
    training_d   = (state_d == S_TRAIN) || (state_d == S_WAIT_ALIGN);
    train_done_d = (state_d == S_DATA);
    train_err_d  = (state_d == S_ERR);
  end

  assign TX_READY    = (state_q == S_DATA);
  assign TX_DATA_OUT = data_out_q;
  assign TRAINING    = training_q;
  assign TRAIN_DONE  = train_done_q;
  assign TRAIN_ERR   = train_err_q;

endmodule

// File: tb/tb_tx_iod_train_gen.sv
// ---------------------------------------------------------------------------
// tb_tx_iod_train_gen
//
// Two instances share one stimulus stream: u_a with default parameters and
// u_b with REV_BITS=0, TRAIN_PATTERN=3C, IDLE_WORD=A5 and short training and
// timeout lengths so its transitions are exercised often. Each instance is
// compared against its own behavioural model after every clock.
// ---------------------------------------------------------------------------
module tb_tx_iod_train_gen;

  localparam int P_IDLE  = 0;
  localparam int P_TRAIN = 1;
  localparam int P_WAIT  = 2;
  localparam int P_DATA  = 3;
  localparam int P_ERR   = 4;

  typedef struct {
    int         ph;
    int         cnt;
    logic [7:0] out;
  } mstate_t;

  typedef struct {
    bit         rev;
    logic [7:0] pat;
    logic [7:0] idle;
    int         min_w;
    int         tmo;
  } cfg_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       train_req = 1'b0;
  logic       rx_align = 1'b0;
  logic [7:0] din = 8'h00;
  logic       vin = 1'b0;

  logic       a_rdy, a_trn, a_done, a_err;
  logic [7:0] a_out;
  logic       b_rdy, b_trn, b_done, b_err;
  logic [7:0] b_out;

  logic [11:0] a_vec, b_vec;
  assign a_vec = {a_out, a_trn, a_done, a_err, a_rdy};
  assign b_vec = {b_out, b_trn, b_done, b_err, b_rdy};

  cfg_t    ca = '{1'b1, 8'h0F, 8'h00, 256, 4096};
  cfg_t    cb = '{1'b0, 8'h3C, 8'hA5, 4, 6};
  mstate_t ma = '{P_IDLE, 0, 8'h00};
  mstate_t mb = '{P_IDLE, 0, 8'hA5};

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  tx_iod_train_gen u_a (
    .SCLK(clk), .RESET(rst), .TRAIN_REQ(train_req), .RX_ALIGN_DONE(rx_align),
    .TX_DATA_IN(din), .TX_VALID_IN(vin), .TX_READY(a_rdy), .TX_DATA_OUT(a_out),
    .TRAINING(a_trn), .TRAIN_DONE(a_done), .TRAIN_ERR(a_err)
  );

  tx_iod_train_gen #(
    .TRAIN_PATTERN(8'h3C), .IDLE_WORD(8'hA5), .REV_BITS(1'b0),
    .MIN_TRAIN_WORDS(4), .ALIGN_TIMEOUT(6)
  ) u_b (
    .SCLK(clk), .RESET(rst), .TRAIN_REQ(train_req), .RX_ALIGN_DONE(rx_align),
    .TX_DATA_IN(din), .TX_VALID_IN(vin), .TX_READY(b_rdy), .TX_DATA_OUT(b_out),
    .TRAINING(b_trn), .TRAIN_DONE(b_done), .TRAIN_ERR(b_err)
  );

  // Behavioural model: one clock edge, written from the link-training rules.
  function automatic mstate_t model_step(mstate_t s, cfg_t c, logic r, logic req,
                                         logic al, logic v, logic [7:0] d);
    mstate_t    n;
    logic [7:0] w;
    logic [7:0] rw;
    if (r) begin
      n.ph  = P_IDLE;
      n.cnt = 0;
      rw    = {<<{c.idle}};
      n.out = c.rev ? rw : c.idle;
      return n;
    end
    if (s.ph == P_IDLE)      w = c.idle;
    else if (s.ph == P_DATA) w = v ? d : c.idle;
    else                     w = c.pat;
    rw    = {<<{w}};
    n.out = c.rev ? rw : w;
    n.ph  = s.ph;
    case (s.ph)
      P_IDLE:  if (req) n.ph = P_TRAIN;
      P_TRAIN: if (s.cnt == c.min_w - 1) n.ph = P_WAIT;
      P_WAIT: begin
        if (req)                    n.ph = P_TRAIN;
        else if (al)                n.ph = P_DATA;
        else if (s.cnt == c.tmo - 1) n.ph = P_ERR;
      end
      P_DATA:  if (req || !al) n.ph = P_TRAIN;
      default: if (req) n.ph = P_TRAIN;
    endcase
    if (n.ph != s.ph) n.cnt = 0;
    else              n.cnt = (s.cnt < 65535) ? s.cnt + 1 : s.cnt;
    return n;
  endfunction

  function automatic logic [11:0] exp_vec(mstate_t s);
    return {s.out, (s.ph == P_TRAIN) || (s.ph == P_WAIT), s.ph == P_DATA,
            s.ph == P_ERR, s.ph == P_DATA};
  endfunction

  task automatic step();
    @(posedge clk);
    ma = model_step(ma, ca, rst, train_req, rx_align, vin, din);
    mb = model_step(mb, cb, rst, train_req, rx_align, vin, din);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; train_req = 1'b0; rx_align = 1'b0; vin = 1'b0; din = 8'h00;
    step(); step();
    checks++;
    if (a_vec !== 12'h000) $display("FAIL reset_a: got %h expected %h", a_vec, 12'h000);
    else passes++;
    checks++;
    if (b_vec !== {8'hA5, 4'b0000}) $display("FAIL reset_b: got %h expected %h", b_vec, {8'hA5, 4'b0000});
    else passes++;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_vec !== 12'h000) $display("FAIL idle_hold_a: got %h expected %h", a_vec, 12'h000);
      else passes++;
      checks++;
      if (b_vec !== exp_vec(mb)) $display("FAIL idle_hold_b: got %h expected %h", b_vec, exp_vec(mb));
      else passes++;
    end
  endtask

  task automatic test_train_default();
    int k;
    train_req = 1'b1;
    step();
    train_req = 1'b0;
    checks++;
    if ({a_trn, a_rdy} !== 2'b10) $display("FAIL train_entry: got trn=%b rdy=%b expected trn=1 rdy=0", a_trn, a_rdy);
    else passes++;
    k = 0;
    while (a_done !== 1'b1 && k < 400) begin
      step();
      k++;
      if (k == 10) rx_align = 1'b1;
      checks++;
      if (a_vec !== exp_vec(ma)) $display("FAIL train_model_a k=%0d: got %h expected %h", k, a_vec, exp_vec(ma));
      else passes++;
      checks++;
      if (b_vec !== exp_vec(mb)) $display("FAIL train_model_b k=%0d: got %h expected %h", k, b_vec, exp_vec(mb));
      else passes++;
      if (k <= 256) begin
        checks++;
        if ({a_out, a_trn, a_rdy} !== {8'hF0, 2'b10})
          $display("FAIL train_word k=%0d: got out=%h trn=%b rdy=%b expected out=f0 trn=1 rdy=0", k, a_out, a_trn, a_rdy);
        else passes++;
      end
    end
    // 256 TRAIN cycles, then DATA on the first WAIT_ALIGN cycle.
    checks++;
    if (k !== 257) $display("FAIL train_length: got %0d edges expected 257", k);
    else passes++;
  endtask

  task automatic test_payload();
    rx_align = 1'b1; vin = 1'b1; din = 8'h01;
    checks++;
    if (a_rdy !== 1'b1) $display("FAIL data_ready: got %b expected 1", a_rdy);
    else passes++;
    step();
    checks++;
    if (a_out !== 8'h80) $display("FAIL payload_01: got %h expected 80", a_out);
    else passes++;
    vin = 1'b0;
    step();
    checks++;
    if (a_out !== 8'h00) $display("FAIL payload_idle: got %h expected 00", a_out);
    else passes++;
    for (int i = 0; i < 16; i++) begin
      vin = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      step();
      checks++;
      if (a_vec !== exp_vec(ma)) $display("FAIL payload_model_a: got %h expected %h", a_vec, exp_vec(ma));
      else passes++;
    end
  endtask

  // Alignment drop and train request in the same DATA cycle.
  task automatic test_retrain_priority();
    train_req = 1'b1; rx_align = 1'b0; vin = 1'b1; din = 8'h55;
    step();
    train_req = 1'b0; vin = 1'b0;
    checks++;
    if ({a_trn, a_done, a_err, a_rdy} !== 4'b1000)
      $display("FAIL retrain_flags: got %b expected 1000", {a_trn, a_done, a_err, a_rdy});
    else passes++;
    checks++;
    if (a_vec !== exp_vec(ma)) $display("FAIL retrain_model_a: got %h expected %h", a_vec, exp_vec(ma));
    else passes++;
  endtask

  // Continues straight from the retrain edge: 256 TRAIN + 4096 WAIT_ALIGN
  // edges before ERR proves the count restarted from 0.
  task automatic test_timeout();
    int k;
    k = 0;
    while (a_err !== 1'b1 && k < 5000) begin
      step();
      k++;
      checks++;
      if (a_vec !== exp_vec(ma)) $display("FAIL timeout_model_a k=%0d: got %h expected %h", k, a_vec, exp_vec(ma));
      else passes++;
    end
    checks++;
    if (k !== 4352) $display("FAIL timeout_length: got %0d edges expected 4352", k);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({a_out, a_err, a_trn} !== {8'hF0, 2'b10})
        $display("FAIL err_hold: got out=%h err=%b trn=%b expected out=f0 err=1 trn=0", a_out, a_err, a_trn);
      else passes++;
    end
    train_req = 1'b1;
    step();
    train_req = 1'b0;
    checks++;
    if ({a_trn, a_err} !== 2'b10) $display("FAIL err_retrain: got trn=%b err=%b expected trn=1 err=0", a_trn, a_err);
    else passes++;
  endtask

  task automatic test_alt_params();
    int  k;
    logic raced;
    rst = 1'b1; rx_align = 1'b0; vin = 1'b0;
    step();
    checks++;
    if (b_vec !== {8'hA5, 4'b0000}) $display("FAIL alt_reset: got %h expected %h", b_vec, {8'hA5, 4'b0000});
    else passes++;
    rst = 1'b0; train_req = 1'b1;
    step();
    train_req = 1'b0;
    k = 0;
    while (b_done !== 1'b1 && k < 40) begin
      // Raise lock exactly on the last allowed WAIT_ALIGN cycle.
      raced    = (mb.ph == P_WAIT) && (mb.cnt == cb.tmo - 1);
      rx_align = raced;
      step();
      k++;
      checks++;
      if (b_vec !== exp_vec(mb)) $display("FAIL alt_model_b k=%0d: got %h expected %h", k, b_vec, exp_vec(mb));
      else passes++;
      if (b_trn === 1'b1) begin
        checks++;
        if (b_out !== 8'h3C) $display("FAIL alt_train_word: got %h expected 3c", b_out);
        else passes++;
      end
      if (raced) begin
        checks++;
        if ({b_done, b_err} !== 2'b10) $display("FAIL timeout_race: got done=%b err=%b expected done=1 err=0", b_done, b_err);
        else passes++;
      end
    end
    rx_align = 1'b1;
    checks++;
    if (b_done !== 1'b1) $display("FAIL alt_data_entry: got %b expected 1", b_done);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      vin = 1'b1;
      din = 8'($urandom);
      step();
      checks++;
      if (b_out !== din) $display("FAIL alt_payload: got %h expected %h", b_out, din);
      else passes++;
    end
    vin = 1'b0;
    step();
    checks++;
    if (b_out !== 8'hA5) $display("FAIL alt_idle_word: got %h expected a5", b_out);
    else passes++;
    vin = 1'b1; din = 8'hFF; rst = 1'b1;
    step();
    checks++;
    if (b_vec !== {8'hA5, 4'b0000}) $display("FAIL alt_mid_data_reset: got %h expected %h", b_vec, {8'hA5, 4'b0000});
    else passes++;
    checks++;
    if (a_vec !== 12'h000) $display("FAIL mid_train_reset_a: got %h expected %h", a_vec, 12'h000);
    else passes++;
    rst = 1'b0; vin = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      train_req = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) rx_align = ~rx_align;
      vin = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      step();
      checks++;
      if (a_vec !== exp_vec(ma)) $display("FAIL random_a i=%0d: got %h expected %h", i, a_vec, exp_vec(ma));
      else passes++;
      checks++;
      if (b_vec !== exp_vec(mb)) $display("FAIL random_b i=%0d: got %h expected %h", i, b_vec, exp_vec(mb));
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_train_default();
    test_payload();
    test_retrain_priority();
    test_timeout();
    test_alt_params();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
